// File: rtl/ram_port_arb_if.sv
// Requester-side bundle of the RAM port arbiter: request handshake,
// request payload and the shared read-return path.
interface ram_port_arb_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned AW   = 10,
   parameter int unsigned DW   = 16
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    req_we;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_rdata;

   // Client engines drive requests and receive grants/responses
   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   // Arbiter receives requests and drives grants/responses
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/ram_port_arb.sv
// Round-robin arbiter sharing one registered RAM port among NREQ requesters.
// One access per clock; a tag pipeline matching the RAM read latency steers
// returned read data to the requester that issued it.
module ram_port_arb #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned AW     = 10,
   parameter int unsigned DW     = 16,
   parameter int unsigned RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   ram_port_arb_if.slave bus,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);
   localparam int unsigned IW  = $clog2(NREQ);
   localparam int unsigned NST = RD_LAT + 1;
   localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

   logic [IW-1:0] ptr;
   logic [IW-1:0] ptr_nxt;
   logic          gnt_any;
   logic [IW-1:0] gnt_id;
   logic [IW:0]   cand;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          sel_we;
   logic [NST-1:0] tag_v;
   logic [IW-1:0]  tag_id [NST];

   // Pick the first valid requester at or after ptr; scanning farthest-first lets the nearest win
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + (IW+1)'(k);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (bus.req_valid[cand[IW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_id  = cand[IW-1:0];
         end
      end
   end

   // Route the granted requester's payload toward the RAM port registers
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (gnt_id == IW'(i)) begin
            sel_addr  = bus.req_addr[i*AW +: AW];
            sel_wdata = bus.req_wdata[i*DW +: DW];
            sel_we    = bus.req_we[i];
         end
      end
   end

   assign ptr_nxt       = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
   assign bus.req_ready = gnt_any ? (NREQ'(1) << gnt_id) : '0;

   // RAM port registers and rotating priority pointer; idle cycles hold addr/din and drop we
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
      end else if (gnt_any) begin
         ptr      <= ptr_nxt;
         ram_we   <= sel_we;
         ram_addr <= sel_addr;
         ram_din  <= sel_wdata;
      end else begin
         ram_we   <= 1'b0;
      end
   end

   // Read tag pipeline, one stage per edge, aligned with RAM dout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_v <= '0;
         for (int s = 0; s < int'(NST); s++) begin
            tag_id[s] <= '0;
         end
      end else begin
         tag_v     <= {tag_v[NST-2:0], gnt_any & ~sel_we};
         tag_id[0] <= gnt_id;
         for (int s = 1; s < int'(NST); s++) begin
            tag_id[s] <= tag_id[s-1];
         end
      end
   end

   assign bus.rsp_valid = tag_v[NST-1] ? (NREQ'(1) << tag_id[NST-1]) : '0;
   assign bus.rsp_rdata = ram_dout;

endmodule

// File: tb/tb_ram_port_arb.sv
// Bench for ram_port_arb: behavioural RAM on the port, and a reference model
// that keeps memory contents, the rotation pointer and the expected response
// timeline at transaction level.
module tb_ram_port_arb;
   localparam int unsigned NREQ   = 4;
   localparam int unsigned AW     = 10;
   localparam int unsigned DW     = 16;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned DEPTH  = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ram_port_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   ram_port_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   // Registered-input, registered-output RAM port: dout valid two edges after inputs
   logic [DW-1:0] ram_mem [DEPTH];
   logic [AW-1:0] ra_q;
   logic          rwe_q;
   logic [DW-1:0] rd_q;
   always @(posedge clk) begin
      ra_q  <= ram_addr;
      rwe_q <= ram_we;
      rd_q  <= ram_din;
      if (rwe_q) ram_mem[ra_q] <= rd_q;
      ram_dout <= ram_mem[ra_q];
   end

   // Requester stimulus
   logic [NREQ-1:0]    s_v  = '0;
   logic [NREQ-1:0]    s_we = '0;
   logic [NREQ*AW-1:0] s_a  = '0;
   logic [NREQ*DW-1:0] s_d  = '0;
   assign bus.req_valid = s_v;
   assign bus.req_we    = s_we;
   assign bus.req_addr  = s_a;
   assign bus.req_wdata = s_d;

   // Reference model state
   typedef struct {
      int            id;
      logic [DW-1:0] data;
      bit            known;
      int            due;
   } exp_t;
   exp_t          expq[$];
   logic [DW-1:0] ref_mem   [DEPTH];
   bit            ref_known [DEPTH];
   int            ptr_m    = 0;
   int            edge_cnt = 0;
   int            total    = 0;
   int            bad      = 0;

   function automatic void set_req(input int i, input logic w, input logic [AW-1:0] ad,
                                   input logic [DW-1:0] da);
      s_we[i]           = w;
      s_a[i*AW +: AW]   = ad;
      s_d[i*DW +: DW]   = da;
   endfunction

   // Expected outputs for the current cycle; then commits the grant for the coming edge
   function automatic void model_step(output logic [NREQ-1:0] e_rdy, output logic [NREQ-1:0] e_rsp,
                                      output logic [DW-1:0] e_data, output bit e_known);
      int g;
      logic [AW-1:0] ad;
      e_rsp   = '0;
      e_data  = '0;
      e_known = 1'b0;
      if (expq.size() > 0 && expq[0].due == edge_cnt) begin
         e_rsp   = NREQ'(1) << expq[0].id;
         e_data  = expq[0].data;
         e_known = expq[0].known;
         void'(expq.pop_front());
      end
      e_rdy = '0;
      g = -1;
      for (int k = 0; k < int'(NREQ); k++) begin
         int i;
         i = (ptr_m + k) % int'(NREQ);
         if (g < 0 && s_v[i]) g = i;
      end
      if (g >= 0) begin
         e_rdy[g] = 1'b1;
         ad = s_a[g*AW +: AW];
         if (s_we[g]) begin
            ref_mem[ad]   = s_d[g*DW +: DW];
            ref_known[ad] = 1'b1;
         end else begin
            expq.push_back('{g, ref_mem[ad], ref_known[ad], edge_cnt + 1 + int'(RD_LAT)});
         end
         ptr_m = (g + 1) % int'(NREQ);
      end
   endfunction

   task automatic tick;
      @(posedge clk);
      edge_cnt++;
   endtask

   task automatic test_reset;
      logic [NREQ-1:0] e_rdy, e_rsp;
      logic [DW-1:0]   e_data;
      bit              e_known;
      s_v = '0;
      #2 rst = 1'b1;
      @(negedge clk); #1;
      total++; if (ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== '0) begin
         bad++; $display("FAIL reset ram regs got we=%b addr=%h din=%h exp 0/0/0", ram_we, ram_addr, ram_din);
      end
      total++; if (bus.rsp_valid !== '0 || bus.req_ready !== '0) begin
         bad++; $display("FAIL reset outputs got rsp=%b rdy=%b exp 0/0", bus.rsp_valid, bus.req_ready);
      end
      @(negedge clk); rst = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         s_v = '1;
         for (int i = 0; i < int'(NREQ); i++) set_req(i, 1'b0, AW'(i + 8), '0);
         #1;
         model_step(e_rdy, e_rsp, e_data, e_known);
         total++; if (bus.req_ready !== e_rdy) begin
            bad++; $display("FAIL reset_pre ready got=%b exp=%b", bus.req_ready, e_rdy);
         end
         total++; if (bus.rsp_valid !== e_rsp) begin
            bad++; $display("FAIL reset_pre rsp_valid got=%b exp=%b", bus.rsp_valid, e_rsp);
         end
         tick();
      end
      @(negedge clk);
      rst = 1'b1;
      s_v = '0;
      #1;
      expq.delete();
      ptr_m = 0;
      total++; if (bus.rsp_valid !== '0 || ram_we !== 1'b0) begin
         bad++; $display("FAIL reset_mid got rsp=%b we=%b exp 0/0", bus.rsp_valid, ram_we);
      end
      tick(); tick();
      @(negedge clk); rst = 1'b0;
      tick();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         total++; if (bus.rsp_valid !== '0 || ram_we !== 1'b0 || bus.req_ready !== '0) begin
            bad++; $display("FAIL reset_idle cyc %0d got rsp=%b we=%b rdy=%b exp 0", c, bus.rsp_valid, ram_we, bus.req_ready);
         end
         tick();
      end
   endtask

   task automatic test_contention;
      logic [NREQ-1:0] e_rdy, e_rsp, want;
      logic [DW-1:0]   e_data;
      bit              e_known;
      // preload addr i with 0x1000+i through requester NREQ-1, leaving ptr at 0
      for (int c = 0; c < int'(NREQ) + 12 + 4; c++) begin
         @(negedge clk);
         if (c < int'(NREQ)) begin
            s_v = '0; s_v[NREQ-1] = 1'b1;
            set_req(NREQ-1, 1'b1, AW'(c), DW'(16'h1000 + c));
         end else if (c < int'(NREQ) + 12) begin
            s_v = '1;
            for (int i = 0; i < int'(NREQ); i++) set_req(i, 1'b0, AW'(i), '0);
         end else begin
            s_v = '0;
         end
         #1;
         model_step(e_rdy, e_rsp, e_data, e_known);
         total++; if (bus.req_ready !== e_rdy) begin
            bad++; $display("FAIL contention ready cyc %0d got=%b exp=%b", c, bus.req_ready, e_rdy);
         end
         if (c >= int'(NREQ) && c < int'(NREQ) + 12) begin
            want = NREQ'(1) << ((c - int'(NREQ)) % int'(NREQ));
            total++; if (bus.req_ready !== want) begin
               bad++; $display("FAIL contention rotation cyc %0d got=%b exp=%b", c, bus.req_ready, want);
            end
         end
         total++; if (bus.rsp_valid !== e_rsp) begin
            bad++; $display("FAIL contention rsp_valid cyc %0d got=%b exp=%b", c, bus.rsp_valid, e_rsp);
         end
         if (e_rsp != '0 && e_known) begin
            total++; if (bus.rsp_rdata !== e_data) begin
               bad++; $display("FAIL contention rdata cyc %0d got=%h exp=%h", c, bus.rsp_rdata, e_data);
            end
         end
         tick();
      end
   endtask

   task automatic test_single;
      logic [NREQ-1:0] e_rdy, e_rsp;
      logic [DW-1:0]   e_data;
      bit              e_known;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         s_v = '0;
         if (c < 2) begin
            s_v[2] = 1'b1;
            set_req(2, (c == 0), AW'(10'h055), 16'hBEEF);
         end
         #1;
         model_step(e_rdy, e_rsp, e_data, e_known);
         total++; if (bus.req_ready !== e_rdy) begin
            bad++; $display("FAIL single ready cyc %0d got=%b exp=%b", c, bus.req_ready, e_rdy);
         end
         total++; if (bus.rsp_valid !== e_rsp) begin
            bad++; $display("FAIL single rsp_valid cyc %0d got=%b exp=%b", c, bus.rsp_valid, e_rsp);
         end
         if (c == 4) begin
            total++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_rdata !== 16'hBEEF) begin
               bad++; $display("FAIL single readback got rsp=%b data=%h exp 0100/beef", bus.rsp_valid, bus.rsp_rdata);
            end
         end
         tick();
      end
   endtask

   task automatic test_wrap;
      logic [NREQ-1:0] e_rdy, e_rsp;
      logic [DW-1:0]   e_data;
      bit              e_known;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         s_v = '0;
         if (c < 8) begin
            s_v = 4'b1010;
            set_req(1, 1'b0, AW'(10'h055), '0);
            set_req(3, 1'b0, AW'(2), '0);
         end
         #1;
         model_step(e_rdy, e_rsp, e_data, e_known);
         total++; if (bus.req_ready !== e_rdy) begin
            bad++; $display("FAIL wrap ready cyc %0d got=%b exp=%b", c, bus.req_ready, e_rdy);
         end
         if (c == 0) begin
            total++; if (bus.req_ready !== 4'b1000) begin
               bad++; $display("FAIL wrap first grant got=%b exp=1000", bus.req_ready);
            end
         end
         total++; if ((bus.req_ready & 4'b0101) !== 4'b0000) begin
            bad++; $display("FAIL wrap idle requesters got=%b exp=0", bus.req_ready & 4'b0101);
         end
         total++; if (bus.rsp_valid !== e_rsp) begin
            bad++; $display("FAIL wrap rsp_valid cyc %0d got=%b exp=%b", c, bus.rsp_valid, e_rsp);
         end
         if (e_rsp != '0 && e_known) begin
            total++; if (bus.rsp_rdata !== e_data) begin
               bad++; $display("FAIL wrap rdata cyc %0d got=%h exp=%h", c, bus.rsp_rdata, e_data);
            end
         end
         tick();
      end
   endtask

   task automatic test_mixed;
      logic [NREQ-1:0] e_rdy, e_rsp;
      logic [DW-1:0]   e_data;
      bit              e_known;
      e_rdy = '0;
      set_req(0, 1'b1, AW'(10'h02A), DW'($urandom));
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (e_rdy[0]) set_req(0, 1'b1, AW'(10'h02A), DW'($urandom));
         set_req(1, 1'b0, AW'(10'h02A), '0);
         s_v = (c < 12) ? 4'b0011 : 4'b0000;
         #1;
         model_step(e_rdy, e_rsp, e_data, e_known);
         total++; if (bus.req_ready !== e_rdy) begin
            bad++; $display("FAIL mixed ready cyc %0d got=%b exp=%b", c, bus.req_ready, e_rdy);
         end
         total++; if (bus.rsp_valid !== e_rsp || bus.rsp_valid[0] !== 1'b0) begin
            bad++; $display("FAIL mixed rsp_valid cyc %0d got=%b exp=%b", c, bus.rsp_valid, e_rsp);
         end
         if (e_rsp != '0 && e_known) begin
            total++; if (bus.rsp_rdata !== e_data) begin
               bad++; $display("FAIL mixed rdata cyc %0d got=%h exp=%h", c, bus.rsp_rdata, e_data);
            end
         end
         tick();
      end
   endtask

   task automatic test_soak;
      logic [NREQ-1:0] e_rdy, e_rsp;
      logic [DW-1:0]   e_data;
      bit              e_known;
      int              wait_cnt [NREQ];
      e_rdy = '0;
      s_v   = '0;
      for (int i = 0; i < int'(NREQ); i++) wait_cnt[i] = 0;
      for (int c = 0; c < 10000 + 12; c++) begin
         @(negedge clk);
         for (int i = 0; i < int'(NREQ); i++) begin
            if (e_rdy[i]) s_v[i] = 1'b0;
            if (!s_v[i] && c < 10000 && ($urandom % 3) != 0) begin
               s_v[i] = 1'b1;
               set_req(i, 1'($urandom % 2), AW'($urandom % 16), DW'($urandom));
            end
         end
         #1;
         model_step(e_rdy, e_rsp, e_data, e_known);
         total++; if (bus.req_ready !== e_rdy) begin
            bad++; $display("FAIL soak ready cyc %0d got=%b exp=%b", c, bus.req_ready, e_rdy);
         end
         total++; if (bus.rsp_valid !== e_rsp) begin
            bad++; $display("FAIL soak rsp_valid cyc %0d got=%b exp=%b", c, bus.rsp_valid, e_rsp);
         end
         if (e_rsp != '0 && e_known) begin
            total++; if (bus.rsp_rdata !== e_data) begin
               bad++; $display("FAIL soak rdata cyc %0d got=%h exp=%h", c, bus.rsp_rdata, e_data);
            end
         end
         for (int i = 0; i < int'(NREQ); i++) begin
            if (s_v[i] && !bus.req_ready[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
         end
         for (int i = 0; i < int'(NREQ); i++) begin
            total++; if (wait_cnt[i] > int'(NREQ) - 1) begin
               bad++; $display("FAIL soak starvation req %0d cyc %0d waited=%0d max=%0d", i, c, wait_cnt[i], NREQ - 1);
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single();
      test_wrap();
      test_mixed();
      test_soak();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
